dmem_access_seq: RTL

Load/store sequencer between the core's memory stage and the word-wide data BRAM. It accepts one access at a time over a valid/ready handshake. Each access is issued as one or two word accesses: two when the access crosses a 32-bit word boundary. Read data is gathered, aligned and sign/zero-extended per RISC-V funct3, and returned over a valid/ready response channel. Store byte enables and write-data lane steering are generated here.

---
 rtl/dmem_access_seq.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/dmem_access_seq.sv
// ---------------------------------------------------------------------------
// dmem_access_seq
//
// Load/store sequencer between the core memory stage and a word-wide data
// BRAM. Takes one access at a time, splits accesses that straddle a 32-bit
// word boundary into a lo/hi word pair, steers store lanes / byte enables,
// and gathers, aligns and extends load data per RISC-V funct3.
//
// Ports
//   i_clk, i_reset_n          clock, async active-low reset
//   i_req_*  / o_req_ready    request channel (we, funct3, byte addr, wdata)
//   o_mem_*  / i_mem_rdata    BRAM port; rdata valid RD_LATENCY after o_mem_en
//   o_rsp_*  / i_rsp_ready    response channel (extended data, illegal-funct3 err)
// ---------------------------------------------------------------------------
module dmem_access_seq #(
    parameter int ADDR_W     = 12,
    parameter int RD_LATENCY = 1
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [2:0]        i_req_funct3,
    input  logic [31:0]       i_req_addr,
    input  logic [31:0]       i_req_wdata,
    output logic              o_mem_en,
    output logic [3:0]        o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    input  logic [31:0]       i_mem_rdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [31:0]       o_rsp_data,
    output logic              o_rsp_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE_LO,
        S_ISSUE_HI,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state_q, state_d;

    // registered request
    logic [ADDR_W+1:0] addr_q;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [31:0]       wdata_q;
    logic              split_q;
    logic              err_q;

    // gathered read words
    logic [31:0]       lo_q, hi_q;

    // read-return tracking: bit i set means a strobe issued i+1 cycles ago
    logic [RD_LATENCY-1:0] lo_vld_pipe, hi_vld_pipe;
    logic                  lo_strb, hi_strb, last_cap;

    // request decode
    logic       accept;
    logic [1:0] req_off, req_sz;
    logic       req_err, req_split;

    // only the BRAM-addressable part of the byte address is used
    logic unused_addr_bits;
    assign unused_addr_bits = ^i_req_addr[31:ADDR_W+2];

    assign req_off = i_req_addr[1:0];
    assign req_sz  = i_req_funct3[1:0];
    assign accept  = i_req_valid && (state_q == S_IDLE);

    always_comb begin
        if (i_req_we)
            req_err = (req_sz == 2'b11);
        else
            req_err = (i_req_funct3 == 3'b011) || (i_req_funct3[2:1] == 2'b11);
    end

    assign req_split = ((req_sz == 2'b01) && (req_off == 2'b11)) ||
                       ((req_sz == 2'b10) && (req_off != 2'b00));

    // store lane steering over a 64-bit lo/hi window
    logic [1:0]  off_q;
    logic [3:0]  size_mask;
    logic [7:0]  mask8;
    logic [63:0] data64;

    assign off_q = addr_q[1:0];

    always_comb begin
        case (f3_q[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    end

    assign mask8  = {4'b0000, size_mask} << off_q;
    assign data64 = {32'd0, wdata_q} << {off_q, 3'b000};

    // word addresses; hi wraps naturally at the top of memory
    logic [ADDR_W-1:0] lo_addr, hi_addr;
    assign lo_addr = addr_q[ADDR_W+1:2];
    assign hi_addr = lo_addr + ADDR_W'(1);

    assign lo_strb  = (state_q == S_ISSUE_LO) && !we_q;
    assign hi_strb  = (state_q == S_ISSUE_HI) && !we_q;
    assign last_cap = split_q ? hi_vld_pipe[RD_LATENCY-1] : lo_vld_pipe[RD_LATENCY-1];

    // ------------------------------------------------------------------
    // state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // ------------------------------------------------------------------
    // next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        o_req_ready = 1'b0;
        o_mem_en    = 1'b0;
        o_mem_we    = 4'b0000;
        o_mem_addr  = '0;
        o_mem_wdata = 32'd0;
        o_rsp_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                o_req_ready = 1'b1;
                if (accept)
                    state_d = req_err ? S_RESP : S_ISSUE_LO;
            end
            S_ISSUE_LO: begin
                o_mem_en   = 1'b1;
                o_mem_addr = lo_addr;
                if (we_q) begin
                    o_mem_we    = mask8[3:0];
                    o_mem_wdata = data64[31:0];
                end
                state_d = split_q ? S_ISSUE_HI : S_WAIT;
            end
            S_ISSUE_HI: begin
                o_mem_en   = 1'b1;
                o_mem_addr = hi_addr;
                if (we_q) begin
                    o_mem_we    = mask8[7:4];
                    o_mem_wdata = data64[63:32];
                end
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // stores need no read return: a single cycle here
                if (we_q || last_cap)
                    state_d = S_RESP;
            end
            S_RESP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // request capture and read gather
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            addr_q      <= '0;
            we_q        <= 1'b0;
            f3_q        <= 3'b000;
            wdata_q     <= 32'd0;
            split_q     <= 1'b0;
            err_q       <= 1'b0;
            lo_q        <= 32'd0;
            hi_q        <= 32'd0;
            lo_vld_pipe <= '0;
            hi_vld_pipe <= '0;
        end else begin
            lo_vld_pipe[0] <= lo_strb;
            hi_vld_pipe[0] <= hi_strb;
            for (int i = 1; i < RD_LATENCY; i++) begin
                lo_vld_pipe[i] <= lo_vld_pipe[i-1];
                hi_vld_pipe[i] <= hi_vld_pipe[i-1];
            end

            if (accept) begin
                addr_q  <= i_req_addr[ADDR_W+1:0];
                we_q    <= i_req_we;
                f3_q    <= i_req_funct3;
                wdata_q <= i_req_wdata;
                split_q <= req_split;
                err_q   <= req_err;
                lo_q    <= 32'd0;
                hi_q    <= 32'd0;
            end else begin
                if (lo_vld_pipe[RD_LATENCY-1])
                    lo_q <= i_mem_rdata;
                if (hi_vld_pipe[RD_LATENCY-1])
                    hi_q <= i_mem_rdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // load align / extend
    // ------------------------------------------------------------------
    logic [31:0] rsp_word, rsp_ext;

    assign rsp_word = 32'({hi_q, lo_q} >> {off_q, 3'b000});

    always_comb begin
        case (f3_q)
            3'b000:  rsp_ext = {{24{rsp_word[7]}},  rsp_word[7:0]};
            3'b001:  rsp_ext = {{16{rsp_word[15]}}, rsp_word[15:0]};
            3'b100:  rsp_ext = {24'd0, rsp_word[7:0]};
            3'b101:  rsp_ext = {16'd0, rsp_word[15:0]};
            default: rsp_ext = rsp_word;
        endcase
    end

    // response fields are only meaningful while presenting a response
    assign o_rsp_err  = (state_q == S_RESP) && err_q;
    assign o_rsp_data = ((state_q == S_RESP) && !err_q && !we_q) ? rsp_ext : 32'd0;

endmodule
